// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Handshaked ALU; ADD/SUB/AND/OR in one cycle, MUL by iterative
//            shift-add consuming MUL_STEP multiplier bits per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int c_STEPS = WIDTH / MUL_STEP;
  localparam int c_CNT_W = $clog2(c_STEPS + 1);

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_MUL = 3'b011;
  localparam logic [2:0] c_OP_SUB = 3'b110;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_single;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_alu_res;
  logic [WIDTH-1:0]   w_partial;
  logic [WIDTH-1:0]   w_acc_sum;

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic               r_zero;

  assign ready_o  = (r_state == S_IDLE);
  assign w_accept = valid_i & ready_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_single     = 1'b0;
    w_mul_start  = 1'b0;
    w_mul_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (ALUCtrl_i == c_OP_MUL) begin
            w_state_next = S_MUL;
            w_mul_start  = 1'b1;
          end else begin
            w_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        // A flush on the final step edge also discards the product.
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == c_CNT_W'(1)) begin
          w_state_next = S_IDLE;
          w_mul_done   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    case (ALUCtrl_i)
      c_OP_ADD: w_alu_res = data1_i + data2_i;
      c_OP_SUB: w_alu_res = data1_i - data2_i;
      c_OP_AND: w_alu_res = data1_i & data2_i;
      c_OP_OR:  w_alu_res = data1_i | data2_i;
      default:  w_alu_res = '0;
    endcase
  end

  // Multiplicand times the low MUL_STEP multiplier bits, as shifted adds.
  always_comb begin
    w_partial = '0;
    for (int b = 0; b < MUL_STEP; b++) begin
      if (r_mplier[b]) begin
        w_partial = w_partial + (r_mcand << b);
      end
    end
  end

  assign w_acc_sum = r_acc + w_partial;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_single) begin
        r_data  <= w_alu_res;
        r_zero  <= (w_alu_res == '0);
        r_valid <= 1'b1;
      end

      if (w_mul_start) begin
        r_acc    <= '0;
        r_mcand  <= data1_i;
        r_mplier <= data2_i;
        r_cnt    <= c_CNT_W'(c_STEPS);
      end else if (r_state == S_MUL) begin
        if (flush_i) begin
          r_cnt <= '0;
        end else begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt - c_CNT_W'(1);
        end
      end

      if (w_mul_done) begin
        r_data  <= w_acc_sum;
        r_zero  <= (w_acc_sum == '0);
        r_valid <= 1'b1;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign Zero_o  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Scoreboard bench for multicycle_alu (MUL_STEP=1 and MUL_STEP=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q1[$];
  exp_t        q4[$];
  logic [31:0] last_d1 = '0;
  logic [31:0] last_d4 = '0;

  logic        vi1 = 1'b0, fl1 = 1'b0, rdy1, vo1, zo1;
  logic [2:0]  op1 = '0;
  logic [31:0] a1 = '0, b1 = '0, do1;
  logic        vi4 = 1'b0, fl4 = 1'b0, rdy4, vo4, zo4;
  logic [2:0]  op4 = '0;
  logic [31:0] a4 = '0, b4 = '0, do4;

  multicycle_alu #(.WIDTH(32), .MUL_STEP(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi1), .ready_o(rdy1), .flush_i(fl1),
    .ALUCtrl_i(op1), .data1_i(a1), .data2_i(b1),
    .valid_o(vo1), .data_o(do1), .Zero_o(zo1)
  );

  multicycle_alu #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi4), .ready_o(rdy4), .flush_i(fl4),
    .ALUCtrl_i(op4), .data1_i(a4), .data2_i(b4),
    .valid_o(vo4), .data_o(do4), .Zero_o(zo4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vo1) begin
        if (q1.size() == 0) check("u1 unexpected valid_o", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("u1 data_o", do1, e.data);
          check("u1 Zero_o", {31'd0, zo1}, {31'd0, e.zero});
          check("u1 valid cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (vo4) begin
        if (q4.size() == 0) check("u4 unexpected valid_o", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          check("u4 data_o", do4, e.data);
          check("u4 Zero_o", {31'd0, zo4}, {31'd0, e.zero});
          check("u4 valid cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  // Drives one request; expected result (hand-computed) is queued with the
  // cycle in which valid_o must appear.
  task automatic issue(input int u, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    exp_t e;
    int   k = 0;
    int   lat;
    while (!((u == 1) ? rdy1 : rdy4) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) check("ready_o wait timeout", 32'd0, 32'd1);
    lat = (op == OP_MUL) ? ((u == 1) ? 33 : 9) : 1;
    if (u == 1) begin vi1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else        begin vi4 = 1'b1; op4 = op; a4 = a; b4 = b; end
    e.data = exp;
    e.zero = (exp == 32'd0);
    e.cyc  = cyc + lat;
    if (push) begin
      if (u == 1) begin q1.push_back(e); last_d1 = exp; end
      else        begin q4.push_back(e); last_d4 = exp; end
    end
    @(posedge clk); #1;
    vi1 = 1'b0;
    vi4 = 1'b0;
  endtask

  task automatic wait_empty();
    int k = 0;
    while ((q1.size() != 0 || q4.size() != 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    int n;
    fork
      mon();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst u1 ready_o", {31'd0, rdy1}, 32'd1);
    check("rst u1 valid_o", {31'd0, vo1}, 32'd0);
    check("rst u1 data_o", do1, 32'd0);
    check("rst u1 Zero_o", {31'd0, zo1}, 32'd0);
    check("rst u4 ready_o", {31'd0, rdy4}, 32'd1);
    check("rst u4 data_o", do4, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle ops, back-to-back
    issue(1, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
    issue(1, OP_SUB, 32'd3, 32'd3, 32'd0, 1'b1);
    issue(1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    issue(1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b1);
    check("b2b ready_o", {31'd0, rdy1}, 32'd1);
    issue(1, OP_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b1);
    check("b2b ready_o", {31'd0, rdy1}, 32'd1);
    issue(1, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b1);
    issue(1, 3'b100, 32'd9, 32'd9, 32'd0, 1'b1);
    issue(1, 3'b111, 32'h1234, 32'h1, 32'd0, 1'b1);
    issue(1, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);

    // MUL, step 1: busy window with ignored requests and changing operands
    issue(1, OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy1) break;
      n++;
      vi1 = (i < 6);
      op1 = OP_ADD;
      a1  = 32'(i);
      b1  = 32'hAAAA_0000;
      @(posedge clk); #1;
    end
    vi1 = 1'b0;
    check("u1 MUL busy cycles", 32'(n), 32'd32);
    issue(1, OP_ADD, 32'd10, 32'd20, 32'd30, 1'b1);

    // MUL, step 4
    issue(4, OP_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy4) break;
      n++;
      @(posedge clk); #1;
    end
    check("u4 MUL busy cycles", 32'(n), 32'd8);
    issue(4, OP_MUL, 32'd0, 32'h0001_2345, 32'd0, 1'b1);
    issue(4, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(4, OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b1);
    wait_empty();

    // Flush at cycle 10 of a MUL
    issue(1, OP_MUL, 32'd5, 32'd6, 32'd30, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    fl1 = 1'b1;
    @(posedge clk); #1;
    fl1 = 1'b0;
    check("flush u1 ready_o", {31'd0, rdy1}, 32'd1);
    check("flush u1 valid_o", {31'd0, vo1}, 32'd0);
    check("flush u1 data_o", do1, last_d1);
    // Flush in IDLE blocks acceptance
    vi1 = 1'b1; fl1 = 1'b1; op1 = OP_ADD; a1 = 32'd1; b1 = 32'd1;
    @(posedge clk); #1;
    vi1 = 1'b0; fl1 = 1'b0;
    check("idle flush u1 valid_o", {31'd0, vo1}, 32'd0);
    check("idle flush u1 data_o", do1, last_d1);
    issue(1, OP_ADD, 32'd100, 32'd23, 32'd123, 1'b1);

    // Flush on the completion edge of a step-4 MUL
    issue(4, OP_MUL, 32'd7, 32'd8, 32'd56, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    fl4 = 1'b1;
    @(posedge clk); #1;
    fl4 = 1'b0;
    check("done flush u4 ready_o", {31'd0, rdy4}, 32'd1);
    check("done flush u4 valid_o", {31'd0, vo4}, 32'd0);
    check("done flush u4 data_o", do4, last_d4);
    wait_empty();

    // Asynchronous reset mid-MUL
    issue(1, OP_MUL, 32'd7, 32'd7, 32'd49, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("async rst ready_o", {31'd0, rdy1}, 32'd1);
    check("async rst valid_o", {31'd0, vo1}, 32'd0);
    check("async rst data_o", do1, 32'd0);
    check("async rst Zero_o", {31'd0, zo1}, 32'd0);
    last_d1 = '0;
    last_d4 = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    issue(1, OP_MUL, 32'd3, 32'd3, 32'd9, 1'b1);
    issue(4, OP_MUL, 32'd3, 32'd3, 32'd9, 1'b1);

    wait_empty();
    repeat (5) begin @(posedge clk); #1; end
    check("u1 scoreboard drained", 32'(q1.size()), 32'd0);
    check("u4 scoreboard drained", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
